// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: streams (w1,w2) word pairs from a dual-read-port ROM
// over valid/ready, and arbitrates loader writes into the ROM while idle.
module weight_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] pair_count,
  output logic                  busy,
  output logic                  done,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  rom_write_en,
  output logic [ADDR_WIDTH-1:0] rom_write_addr,
  output logic [DATA_WIDTH-1:0] rom_write_data,
  output logic [ADDR_WIDTH-1:0] rom_read_addr_1,
  output logic [ADDR_WIDTH-1:0] rom_read_addr_2,
  input  logic [DATA_WIDTH-1:0] rom_read_data_1,
  input  logic [DATA_WIDTH-1:0] rom_read_data_2,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data_1,
  output logic [DATA_WIDTH-1:0] w_data_2,
  output logic                  w_last
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_w_valid;
  logic                  r_w_last;
  logic [DATA_WIDTH-1:0] r_w_data_1;
  logic [DATA_WIDTH-1:0] r_w_data_2;
  logic [ADDR_WIDTH-1:0] r_rd_addr_1;
  logic [ADDR_WIDTH-1:0] r_rd_addr_2;
  logic [ADDR_WIDTH-1:0] r_remain;

  logic [1:0]            w_state_nxt;
  logic                  w_valid_nxt;
  logic                  w_last_nxt;
  logic [DATA_WIDTH-1:0] w_data_1_nxt;
  logic [DATA_WIDTH-1:0] w_data_2_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_addr_1_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_addr_2_nxt;
  logic [ADDR_WIDTH-1:0] w_remain_nxt;
  logic                  w_handshake;

  // Address arithmetic wraps modulo the ROM depth.
  function automatic logic [ADDR_WIDTH-1:0] addr_add(input logic [ADDR_WIDTH-1:0] a,
                                                     input int unsigned inc);
    return ADDR_WIDTH'((32'(a) + inc) % DEPTH);
  endfunction

  assign w_handshake = r_w_valid & w_ready;

  // r_remain counts pairs still to be presented after the one on the bus.
  always_comb begin
    w_state_nxt     = r_state;
    w_valid_nxt     = r_w_valid;
    w_last_nxt      = r_w_last;
    w_data_1_nxt    = r_w_data_1;
    w_data_2_nxt    = r_w_data_2;
    w_rd_addr_1_nxt = r_rd_addr_1;
    w_rd_addr_2_nxt = r_rd_addr_2;
    w_remain_nxt    = r_remain;
    case (r_state)
      S_IDLE: begin
        if (!ld_valid && start) begin
          if (pair_count == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_remain_nxt    = pair_count;
            w_rd_addr_1_nxt = base_addr;
            w_rd_addr_2_nxt = addr_add(base_addr, 1);
            w_state_nxt     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_data_1_nxt    = rom_read_data_1;
        w_data_2_nxt    = rom_read_data_2;
        w_valid_nxt     = 1'b1;
        w_last_nxt      = (r_remain == ADDR_WIDTH'(1));
        w_remain_nxt    = r_remain - ADDR_WIDTH'(1);
        w_rd_addr_1_nxt = addr_add(r_rd_addr_1, 2);
        w_rd_addr_2_nxt = addr_add(r_rd_addr_2, 2);
        w_state_nxt     = S_STREAM;
      end
      S_STREAM: begin
        if (w_handshake) begin
          if (r_w_last) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_data_1_nxt    = rom_read_data_1;
            w_data_2_nxt    = rom_read_data_2;
            w_last_nxt      = (r_remain == ADDR_WIDTH'(1));
            w_remain_nxt    = r_remain - ADDR_WIDTH'(1);
            w_rd_addr_1_nxt = addr_add(r_rd_addr_1, 2);
            w_rd_addr_2_nxt = addr_add(r_rd_addr_2, 2);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_valid   <= 1'b0;
      r_w_last    <= 1'b0;
      r_w_data_1  <= '0;
      r_w_data_2  <= '0;
      r_rd_addr_1 <= '0;
      r_rd_addr_2 <= '0;
      r_remain    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_w_valid   <= w_valid_nxt;
      r_w_last    <= w_last_nxt;
      r_w_data_1  <= w_data_1_nxt;
      r_w_data_2  <= w_data_2_nxt;
      r_rd_addr_1 <= w_rd_addr_1_nxt;
      r_rd_addr_2 <= w_rd_addr_2_nxt;
      r_remain    <= w_remain_nxt;
    end
  end

  // Loader writes pass straight through, only while idle.
  assign ld_ready       = (r_state == S_IDLE);
  assign rom_write_en   = ld_valid & ld_ready;
  assign rom_write_addr = ld_addr;
  assign rom_write_data = ld_data;

  assign busy            = r_busy;
  assign done            = r_done;
  assign w_valid         = r_w_valid;
  assign w_last          = r_w_last;
  assign w_data_1        = r_w_data_1;
  assign w_data_2        = r_w_data_2;
  assign rom_read_addr_1 = r_rd_addr_1;
  assign rom_read_addr_2 = r_rd_addr_2;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a behavioural dual-port ROM
// (writes on posedge, reads on negedge).
module tb_weight_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic [3:0]  pair_count;
  logic        busy;
  logic        done;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic        rom_write_en;
  logic [3:0]  rom_write_addr;
  logic [15:0] rom_write_data;
  logic [3:0]  rom_read_addr_1;
  logic [3:0]  rom_read_addr_2;
  logic [15:0] rom_read_data_1;
  logic [15:0] rom_read_data_2;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data_1;
  logic [15:0] w_data_2;
  logic        w_last;

  logic [15:0] mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  weight_fetch_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pair_count(pair_count),
    .busy(busy), .done(done), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .rom_write_en(rom_write_en), .rom_write_addr(rom_write_addr),
    .rom_write_data(rom_write_data), .rom_read_addr_1(rom_read_addr_1),
    .rom_read_addr_2(rom_read_addr_2), .rom_read_data_1(rom_read_data_1),
    .rom_read_data_2(rom_read_data_2), .w_valid(w_valid), .w_ready(w_ready),
    .w_data_1(w_data_1), .w_data_2(w_data_2), .w_last(w_last)
  );

  always #5 clk = ~clk;

  // ROM model
  initial for (int i = 0; i < 16; i++) mem[i] = 16'(i * 257);
  always @(posedge clk) if (rom_write_en) mem[rom_write_addr] <= rom_write_data;
  always @(negedge clk) begin
    rom_read_data_1 <= mem[rom_read_addr_1];
    rom_read_data_2 <= mem[rom_read_addr_2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; pair_count = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; w_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, w_valid, w_last} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, w_valid, w_last});
    end
    n_checks++;
    if ({w_data_1, w_data_2, rom_read_addr_1, rom_read_addr_2} !== 40'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {w_data_1, w_data_2, rom_read_addr_1, rom_read_addr_2});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 16'h1111;
    #1;
    n_checks++;
    if ({ld_ready, rom_write_en} !== 2'b11) begin
      n_fail++; $display("FAIL load_accept: got %b expected 11", {ld_ready, rom_write_en});
    end
    tick();
    load(4'd1, 16'h2222); load(4'd2, 16'h3333); load(4'd3, 16'h4444);
    w_ready = 1'b1; start = 1'b1; base_addr = 4'd0; pair_count = 4'd2;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, w_valid, rom_read_addr_1, rom_read_addr_2} !== {1'b1, 1'b0, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL basic_issue: got %h expected %h", {busy, w_valid, rom_read_addr_1, rom_read_addr_2}, {1'b1, 1'b0, 4'd0, 4'd1});
    end
    tick();
    n_checks++;
    if ({w_valid, w_last, w_data_1, w_data_2} !== {1'b1, 1'b0, 16'h1111, 16'h2222}) begin
      n_fail++; $display("FAIL basic_pair1: got %h expected %h", {w_valid, w_last, w_data_1, w_data_2}, {1'b1, 1'b0, 16'h1111, 16'h2222});
    end
    tick();
    n_checks++;
    if ({w_valid, w_last, done, w_data_1, w_data_2} !== {1'b1, 1'b1, 1'b0, 16'h3333, 16'h4444}) begin
      n_fail++; $display("FAIL basic_pair2: got %h expected %h", {w_valid, w_last, done, w_data_1, w_data_2}, {1'b1, 1'b1, 1'b0, 16'h3333, 16'h4444});
    end
    tick();
    n_checks++;
    if ({w_valid, w_last, done, busy} !== 4'b0011) begin
      n_fail++; $display("FAIL basic_done: got %b expected 0011", {w_valid, w_last, done, busy});
    end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle: got %b expected 00", {done, busy});
    end
  endtask

  task automatic test_backpressure();
    w_ready = 1'b0; start = 1'b1; base_addr = 4'd0; pair_count = 4'd2;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({w_valid, w_last, w_data_1, w_data_2, rom_read_addr_1, rom_read_addr_2} !==
          {1'b1, 1'b0, 16'h1111, 16'h2222, 4'd2, 4'd3}) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h expected %h", i,
          {w_valid, w_last, w_data_1, w_data_2, rom_read_addr_1, rom_read_addr_2},
          {1'b1, 1'b0, 16'h1111, 16'h2222, 4'd2, 4'd3});
      end
    end
    w_ready = 1'b1;
    tick();
    n_checks++;
    if ({w_valid, w_last, w_data_1, w_data_2} !== {1'b1, 1'b1, 16'h3333, 16'h4444}) begin
      n_fail++; $display("FAIL bp_pair2: got %h expected %h", {w_valid, w_last, w_data_1, w_data_2}, {1'b1, 1'b1, 16'h3333, 16'h4444});
    end
    tick();
    n_checks++;
    if ({w_valid, done} !== 2'b01) begin
      n_fail++; $display("FAIL bp_done: got %b expected 01", {w_valid, done});
    end
    tick();
  endtask

  task automatic test_wrap();
    load(4'd14, 16'hAAAA); load(4'd15, 16'hBBBB); load(4'd0, 16'hCCCC); load(4'd1, 16'hDDDD);
    w_ready = 1'b1; start = 1'b1; base_addr = 4'd14; pair_count = 4'd2;
    tick();
    start = 1'b0;
    n_checks++;
    if ({rom_read_addr_1, rom_read_addr_2} !== {4'd14, 4'd15}) begin
      n_fail++; $display("FAIL wrap_addr0: got %h expected %h", {rom_read_addr_1, rom_read_addr_2}, {4'd14, 4'd15});
    end
    tick();
    n_checks++;
    if ({w_valid, w_last, w_data_1, w_data_2, rom_read_addr_1, rom_read_addr_2} !==
        {1'b1, 1'b0, 16'hAAAA, 16'hBBBB, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL wrap_pair1: got %h expected %h",
        {w_valid, w_last, w_data_1, w_data_2, rom_read_addr_1, rom_read_addr_2},
        {1'b1, 1'b0, 16'hAAAA, 16'hBBBB, 4'd0, 4'd1});
    end
    tick();
    n_checks++;
    if ({w_valid, w_last, w_data_1, w_data_2} !== {1'b1, 1'b1, 16'hCCCC, 16'hDDDD}) begin
      n_fail++; $display("FAIL wrap_pair2: got %h expected %h", {w_valid, w_last, w_data_1, w_data_2}, {1'b1, 1'b1, 16'hCCCC, 16'hDDDD});
    end
    tick();
    tick();
  endtask

  task automatic test_zero_count();
    start = 1'b1; base_addr = 4'd3; pair_count = 4'd0;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, done, w_valid} !== 3'b110) begin
      n_fail++; $display("FAIL zero_done: got %b expected 110", {busy, done, w_valid});
    end
    tick();
    n_checks++;
    if ({busy, done, w_valid} !== 3'b000) begin
      n_fail++; $display("FAIL zero_idle: got %b expected 000", {busy, done, w_valid});
    end
    tick();
    n_checks++;
    if ({busy, done, w_valid} !== 3'b000) begin
      n_fail++; $display("FAIL zero_stay: got %b expected 000", {busy, done, w_valid});
    end
  endtask

  task automatic test_loader_priority();
    w_ready = 1'b0; start = 1'b1; base_addr = 4'd0; pair_count = 4'd1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'h5555;
    #1;
    n_checks++;
    if ({ld_ready, rom_write_en} !== 2'b00) begin
      n_fail++; $display("FAIL ld_blocked_issue: got %b expected 00", {ld_ready, rom_write_en});
    end
    tick();
    n_checks++;
    if ({ld_ready, rom_write_en, w_valid} !== 3'b001) begin
      n_fail++; $display("FAIL ld_blocked_stream: got %b expected 001", {ld_ready, rom_write_en, w_valid});
    end
    w_ready = 1'b1;
    tick();
    n_checks++;
    if ({ld_ready, rom_write_en, done} !== 3'b001) begin
      n_fail++; $display("FAIL ld_blocked_done: got %b expected 001", {ld_ready, rom_write_en, done});
    end
    tick();
    n_checks++;
    if ({ld_ready, rom_write_en, busy} !== 3'b110) begin
      n_fail++; $display("FAIL ld_idle_accept: got %b expected 110", {ld_ready, rom_write_en, busy});
    end
    tick();
    ld_addr = 4'd2; ld_data = 16'h7777;
    start = 1'b1; base_addr = 4'd2; pair_count = 4'd1;
    tick();
    ld_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ld_priority: busy got %b expected 0", busy);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, rom_read_addr_1, rom_read_addr_2} !== {1'b1, 4'd2, 4'd3}) begin
      n_fail++; $display("FAIL ld_then_start: got %h expected %h", {busy, rom_read_addr_1, rom_read_addr_2}, {1'b1, 4'd2, 4'd3});
    end
    tick();
    n_checks++;
    if ({w_valid, w_last, w_data_1, w_data_2} !== {1'b1, 1'b1, 16'h7777, 16'h4444}) begin
      n_fail++; $display("FAIL ld_coherent: got %h expected %h", {w_valid, w_last, w_data_1, w_data_2}, {1'b1, 1'b1, 16'h7777, 16'h4444});
    end
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    w_ready = 1'b1; start = 1'b1; base_addr = 4'd0; pair_count = 4'd4;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if ({w_valid, w_data_1, w_data_2} !== {1'b1, 16'hCCCC, 16'hDDDD}) begin
      n_fail++; $display("FAIL abort_pair1: got %h expected %h", {w_valid, w_data_1, w_data_2}, {1'b1, 16'hCCCC, 16'hDDDD});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, w_valid, w_last, done} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_immediate: got %b expected 0000", {busy, w_valid, w_last, done});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({busy, done, w_valid} !== 3'b000) begin
        n_fail++; $display("FAIL abort_no_done%0d: got %b expected 000", i, {busy, done, w_valid});
      end
    end
    start = 1'b1; base_addr = 4'd4; pair_count = 4'd1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if ({w_valid, w_last, w_data_1, w_data_2} !== {1'b1, 1'b1, 16'h0404, 16'h5555}) begin
      n_fail++; $display("FAIL abort_refetch: got %h expected %h", {w_valid, w_last, w_data_1, w_data_2}, {1'b1, 1'b1, 16'h0404, 16'h5555});
    end
    tick();
    n_checks++;
    if ({w_valid, done, busy} !== 3'b011) begin
      n_fail++; $display("FAIL abort_refetch_done: got %b expected 011", {w_valid, done, busy});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_loader_priority();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
